// File: rtl/hubris_fetch_queue_if.sv
// Handshake bundle for the Hubris fetch queue: redirect input, instruction
// memory request/response port, decode-side output and the debug occupancy.
// The master modport is the fetch queue; the slave modport is its environment.
interface hubris_fetch_queue_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INST_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 4
);
  localparam int OCC_W = $clog2(QUEUE_DEPTH) + 1;

  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [INST_WIDTH-1:0] imem_rsp_data;
  logic                  id_valid;
  logic                  id_ready;
  logic [INST_WIDTH-1:0] id_inst;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic [OCC_W-1:0]      occupancy;

  modport master (
    input  redirect_valid, redirect_addr,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output id_valid, id_inst, id_pc,
    input  id_ready,
    output occupancy
  );

  modport slave (
    output redirect_valid, redirect_addr,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  id_valid, id_inst, id_pc,
    output id_ready,
    input  occupancy
  );
endinterface

// File: rtl/hubris_fetch_queue.sv
// Hubris decoupled instruction-fetch stage.
// Generates sequential PCs, issues valid/ready requests to instruction memory,
// collects in-order variable-latency responses into a circular prefetch queue
// and hands instructions to decode over a valid/ready handshake.
// A redirect flushes the queue; responses still in flight for the flushed
// stream are counted in r_stale and discarded when they arrive.
// Optional build macro HUBRIS_FETCH_BYPASS_EN: a response arriving for an
// empty-of-filled-entries queue is presented to decode in the same cycle.
module hubris_fetch_queue #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INST_WIDTH  = 32,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter int                    PC_STEP     = 4,
  parameter logic [INST_WIDTH-1:0] NOP_INST    = 32'h0000_0013
) (
  input logic                   clk,
  input logic                   reset,
  hubris_fetch_queue_if.master  bus
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Architectural fetch state. Entries head..fill-1 are filled, fill..tail-1
  // are allocated and waiting for their response, so the per-entry filled
  // flag is implied by the pointers and r_unf.
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_fill;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_occ;
  logic [CNT_W-1:0]      r_unf;
  logic [CNT_W-1:0]      r_stale;
  logic [ADDR_WIDTH-1:0] r_q_pc   [QUEUE_DEPTH];
  logic [INST_WIDTH-1:0] r_q_inst [QUEUE_DEPTH];

  logic                  w_live;
  logic                  w_credit_ok;
  logic                  w_req_valid;
  logic                  w_issue;
  logic                  w_rsp_stale;
  logic                  w_rsp_fill;
  logic                  w_head_filled;
  logic                  w_bypass;
  logic                  w_id_valid;
  logic                  w_pop;
  logic                  w_store;
  logic [INST_WIDTH-1:0] w_id_inst;
  logic [ADDR_WIDTH-1:0] w_id_pc;

  // Credit check uses start-of-cycle counts only: an entry popped this cycle
  // does not free a slot for a request in the same cycle.
  assign w_live        = !reset && !bus.redirect_valid;
  assign w_credit_ok   = ({1'b0, r_occ} + {1'b0, r_stale}) < (CNT_W + 1)'(QUEUE_DEPTH);
  assign w_req_valid   = w_live && w_credit_ok;
  assign w_issue       = w_req_valid && bus.imem_req_ready;
  assign w_rsp_stale   = bus.imem_rsp_valid && (r_stale != {CNT_W{1'b0}});
  assign w_rsp_fill    = bus.imem_rsp_valid && (r_stale == {CNT_W{1'b0}});
  assign w_head_filled = (r_occ != r_unf);

`ifdef HUBRIS_FETCH_BYPASS_EN
  // No filled entries but something outstanding means head == fill, so a
  // fresh response belongs to the head entry and can go straight to decode.
  assign w_bypass = w_rsp_fill && !w_head_filled && (r_unf != {CNT_W{1'b0}});
`else
  assign w_bypass = 1'b0;
`endif

  assign w_id_valid = w_live && (w_head_filled || w_bypass);
  assign w_pop      = w_id_valid && bus.id_ready;
  // A bypassed response that decode accepts is consumed without a queue write.
  assign w_store    = w_live && w_rsp_fill && !(w_bypass && w_pop);

  // Decode-side data select: NOP and zero PC whenever nothing is offered.
  always_comb begin
    w_id_inst = NOP_INST;
    w_id_pc   = {ADDR_WIDTH{1'b0}};
    if (w_id_valid) begin
      w_id_pc = r_q_pc[r_head];
      if (w_head_filled) begin
        w_id_inst = r_q_inst[r_head];
      end else begin
        w_id_inst = bus.imem_rsp_data;
      end
    end else begin
      w_id_inst = NOP_INST;
      w_id_pc   = {ADDR_WIDTH{1'b0}};
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.id_valid       = w_id_valid;
  assign bus.id_inst        = w_id_inst;
  assign bus.id_pc          = w_id_pc;
  assign bus.occupancy      = r_occ;

  // PC, pointers and counters: reset, then redirect flush, then normal flow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_head  <= {PTR_W{1'b0}};
      r_fill  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_occ   <= {CNT_W{1'b0}};
      r_unf   <= {CNT_W{1'b0}};
      r_stale <= {CNT_W{1'b0}};
    end else if (bus.redirect_valid) begin
      // Every outstanding request of the flushed stream becomes stale. A
      // response arriving now answers one of them (stale or unfilled alike),
      // so it is dropped and removed from the outstanding total.
      r_pc    <= bus.redirect_addr;
      r_head  <= {PTR_W{1'b0}};
      r_fill  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_occ   <= {CNT_W{1'b0}};
      r_unf   <= {CNT_W{1'b0}};
      r_stale <= r_stale + r_unf - CNT_W'(bus.imem_rsp_valid);
    end else begin
      if (w_issue) begin
        r_tail <= r_tail + PTR_W'(1);
        r_pc   <= r_pc + ADDR_WIDTH'(PC_STEP);
      end
      if (w_rsp_stale) begin
        r_stale <= r_stale - CNT_W'(1);
      end
      if (w_rsp_fill) begin
        r_fill <= r_fill + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_occ <= r_occ + CNT_W'(w_issue) - CNT_W'(w_pop);
      r_unf <= r_unf + CNT_W'(w_issue) - CNT_W'(w_rsp_fill);
    end
  end

  // Queue payload storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_q_pc[r_tail] <= r_pc;
    end
    if (w_store) begin
      r_q_inst[r_fill] <= bus.imem_rsp_data;
    end
  end
endmodule
